pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Pipelined successor to the single-cycle controller: decodes each fetched instruction into the RV32 control bundle (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUop, Branch) and carries it through EX, MEM and WB registers. It sits between fetch and the pipelined datapath and handles stall, branch flush and halt drain. It also keeps a retired-instruction counter, so the datapath receives per-stage controls instead of one combinational set.

## Interface
- CNT_W, 32, width of instret counter
- ENABLE_IMM_ALU, 1, decode OP-IMM (0010011) as ALU-immediate; 0 makes it illegal
- HALT_OPCODE, 7'b1110011, opcode treated as halt
- HALT_ON_ILLEGAL, 1, illegal opcode behaves as halt; 0 makes it a bubble

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- if_valid  in  1  if_instr holds an instruction
- if_instr  in  32  instruction word
- if_ready  out  1  decoder accepts this cycle
- stall  in  1  load-use stall: hold fetch, bubble into EX
- flush  in  1  branch taken in MEM: kill EX and decode
- resume  in  1  leave HALTED
- ex_valid, ex_ALUSrc  out  1 each
- ex_ALUop  out  2
- ex_Funct3  out  3
- ex_Funct7  out  7
- ex_rd  out  5
- mem_valid, mem_MemRead, mem_MemWrite, mem_Branch  out  1 each
- wb_valid, wb_RegWrite, wb_MemtoReg  out  1 each
- wb_rd  out  5
- halted  out  1  state is HALTED
- illegal  out  1  sticky illegal-opcode flag
- instret  out  CNT_W  retired-instruction count

## Operation
- Accept condition: if_valid & if_ready. if_ready = (state==RUN) & !stall & !flush & !reset.
- Decode by opcode, written as ALUSrc/MemtoReg/RegWrite/MemRead/MemWrite/Branch, ALUop:
  - 0110011 R: 0/0/1/0/0/0, 10
  - 0000011 load: 1/1/1/1/0/0, 00
  - 0100011 store: 1/0/0/0/1/0, 00
  - 1100011 branch: 0/0/0/0/0/1, 01
  - 0010011 (when ENABLE_IMM_ALU): 1/0/1/0/0/0, 11
  - HALT_OPCODE: all 0, halt marker set
  - other: illegal; set illegal; when HALT_ON_ILLEGAL, treat as halt, otherwise insert a bubble
- Funct3 = instr[14:12], Funct7 = instr[31:25], rd = instr[11:7] (rd forced 0 when RegWrite=0).
- Whenever a stage's valid=0, all of its control outputs are 0.
- Per-edge update, with flush taking priority over stall:
  - EX: loaded with the decoded bundle when accepted; with a bubble on flush, on stall, or when nothing is accepted
  - MEM: loaded from EX, or a bubble on flush
  - WB: loaded from MEM
- Halt FSM:
  - RUN → DRAIN when a halt marker is accepted
  - DRAIN → RUN when flush occurs while the marker is in EX (marker killed)
  - DRAIN → HALTED on the edge where the marker leaves WB
  - HALTED → RUN on resume; resume also clears illegal
  - resume is ignored in RUN and DRAIN
- The halt marker has valid=1 in every stage but writes nothing.
- instret increments on each edge where wb_valid is 1 and the WB entry is not a halt marker; it wraps modulo 2^CNT_W.

## Timing
- Reset:
  - state RUN; all valid and control outputs 0; illegal 0; instret 0; halted 0
  - if_ready 0 while reset is high
- Reset mid-DRAIN returns to RUN with an empty pipeline.
- Latency: instruction accepted at cycle t appears in EX at t+1, MEM at t+2, WB at t+3; it is counted at the t+3→t+4 edge.
- Halt accepted at t: if_ready 0 from t+1; halted 1 from t+4.
- if_ready is combinational from state, stall, flush and reset; all other outputs are registered.
- Simultaneous stall and flush: flush semantics apply, EX gets a bubble, no accept.

## Test plan
- Reset, then R, load, store, branch on consecutive cycles, all stall/flush 0 → ex_ALUop 10,00,00,01 at cycles 1-4; mem_MemRead 1 at cycle 3; instret 4 after cycle 7.
- Load at t, then stall=1 at t+1 → if_ready 0 at t+1; ex_valid 0 at t+2; the held instruction enters EX at t+3.
- Branch in MEM with flush=1, ADD in EX and SUB presented → both killed; mem_valid 0 next cycle; instret excludes them.
- Halt accepted at t=5 → if_ready 0 from 6, halted 1 at 9; resume at 12 → if_ready 1 at 13.
- Halt in EX while flush=1 → state RUN next cycle; halted never asserts.
- Opcode 1111111 with HALT_ON_ILLEGAL=1 → illegal 1, halted after 4 cycles; repeat with HALT_ON_ILLEGAL=0 → bubble, no halt, illegal stays 1 until reset.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
`timescale 1ns/1ps
// pipe_ctrl_unit
//   Decodes fetched RV32 instructions into the control bundle and carries it
//   through EX, MEM and WB registers. Handles load-use stall, branch flush
//   and a halt drain, and counts retired instructions.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   if_valid/if_instr   fetched instruction; if_ready = decoder accepts
//   stall, flush        load-use hold / branch kill (flush wins)
//   resume              leave HALTED (also clears illegal)
//   ex_*, mem_*, wb_*   per-stage valid and controls (0 when stage invalid)
//   halted, illegal     HALTED state / sticky illegal-opcode flag
//   instret             retired-instruction count (wraps)
module pipe_ctrl_unit #(
  parameter int         CNT_W           = 32,
  parameter bit         ENABLE_IMM_ALU  = 1'b1,
  parameter logic [6:0] HALT_OPCODE     = 7'b1110011,
  parameter bit         HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  output logic             if_ready,
  input  logic             stall,
  input  logic             flush,
  input  logic             resume,
  output logic             ex_valid,
  output logic             ex_ALUSrc,
  output logic [1:0]       ex_ALUop,
  output logic [2:0]       ex_Funct3,
  output logic [6:0]       ex_Funct7,
  output logic [4:0]       ex_rd,
  output logic             mem_valid,
  output logic             mem_MemRead,
  output logic             mem_MemWrite,
  output logic             mem_Branch,
  output logic             wb_valid,
  output logic             wb_RegWrite,
  output logic             wb_MemtoReg,
  output logic [4:0]       wb_rd,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;
  localparam int         STAGES   = 2;   // vld_pipe: [0]=EX [1]=MEM [2]=WB

  typedef struct packed {
    logic       alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, halt;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
  } ex_t;

  typedef struct packed {
    logic       mem_read, mem_write, branch, reg_write, mem_to_reg, halt;
    logic [4:0] rd;
  } mem_t;

  typedef struct packed {
    logic       reg_write, mem_to_reg, halt;
    logic [4:0] rd;
  } wb_t;

  logic [1:0]        state;
  logic [STAGES:0]   vld_pipe;
  ex_t               dec, ex_q;
  mem_t              mem_q;
  wb_t               wb_q;
  logic              dec_ill, dec_ok, accept, take;
  logic              unused_instr_bits;

  assign unused_instr_bits = ^if_instr[24:15];

  assign if_ready = (state == S_RUN) & ~stall & ~flush & ~reset;
  assign accept   = if_valid & if_ready;
  // an illegal opcode becomes a bubble unless it is promoted to a halt
  assign dec_ok   = ~(dec_ill & ~HALT_ON_ILLEGAL);
  assign take     = accept & dec_ok;

  always_comb begin
    dec     = '0;
    dec_ill = 1'b0;
    if (if_instr[6:0] == HALT_OPCODE) begin
      dec.halt = 1'b1;
    end else begin
      case (if_instr[6:0])
        7'b0110011: begin dec.reg_write = 1'b1; dec.alu_op = 2'b10; end
        7'b0000011: begin
          dec.alu_src = 1'b1; dec.mem_to_reg = 1'b1;
          dec.reg_write = 1'b1; dec.mem_read = 1'b1;
        end
        7'b0100011: begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; end
        7'b1100011: begin dec.branch = 1'b1; dec.alu_op = 2'b01; end
        7'b0010011: begin
          if (ENABLE_IMM_ALU) begin
            dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 2'b11;
          end else begin
            dec_ill = 1'b1;
          end
        end
        default: dec_ill = 1'b1;
      endcase
    end
    dec.halt = dec.halt | (dec_ill & HALT_ON_ILLEGAL);
    // halt markers carry no payload at all
    if (!dec.halt) begin
      dec.funct3 = if_instr[14:12];
      dec.funct7 = if_instr[31:25];
    end
    if (dec.reg_write) dec.rd = if_instr[11:7];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_RUN;
      vld_pipe <= '0;
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      illegal  <= 1'b0;
      instret  <= '0;
    end else begin
      // accept already excludes stall/flush, so a non-take is a bubble
      vld_pipe[0] <= take;
      ex_q        <= take ? dec : '0;
      vld_pipe[1] <= vld_pipe[0] & ~flush;
      mem_q       <= flush ? '0 : mem_t'{ex_q.mem_read, ex_q.mem_write, ex_q.branch,
                                         ex_q.reg_write, ex_q.mem_to_reg, ex_q.halt, ex_q.rd};
      vld_pipe[2] <= vld_pipe[1];
      wb_q        <= wb_t'{mem_q.reg_write, mem_q.mem_to_reg, mem_q.halt, mem_q.rd};

      if (accept && dec_ill)                illegal <= 1'b1;
      else if (state == S_HALTED && resume) illegal <= 1'b0;

      if (vld_pipe[2] && !wb_q.halt) instret <= instret + CNT_W'(1);

      case (state)
        S_RUN:    if (take && dec.halt) state <= S_DRAIN;
        // flush kills the marker only while it is still in EX
        S_DRAIN:  if (flush && vld_pipe[0] && ex_q.halt) state <= S_RUN;
                  else if (vld_pipe[2] && wb_q.halt)     state <= S_HALTED;
        S_HALTED: if (resume) state <= S_RUN;
        default:  state <= S_RUN;
      endcase
    end
  end

  assign halted       = (state == S_HALTED);
  assign ex_valid     = vld_pipe[0];
  assign ex_ALUSrc    = ex_q.alu_src;
  assign ex_ALUop     = ex_q.alu_op;
  assign ex_Funct3    = ex_q.funct3;
  assign ex_Funct7    = ex_q.funct7;
  assign ex_rd        = ex_q.rd;
  assign mem_valid    = vld_pipe[1];
  assign mem_MemRead  = mem_q.mem_read;
  assign mem_MemWrite = mem_q.mem_write;
  assign mem_Branch   = mem_q.branch;
  assign wb_valid     = vld_pipe[2];
  assign wb_RegWrite  = wb_q.reg_write;
  assign wb_MemtoReg  = wb_q.mem_to_reg;
  assign wb_rd        = wb_q.rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
`timescale 1ns/1ps
module tb_pipe_ctrl_unit;
  localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_ST = 7'b0100011,
                         OP_BR = 7'b1100011, OP_IMM = 7'b0010011;
  localparam logic [31:0] HALT_I = 32'h0000_0073, ILL_I = 32'h0000_007F;

  logic clk = 1'b0;
  logic reset, if_valid, stall, flush, resume;
  logic [31:0] if_instr;
  logic if_ready, ex_valid, ex_ALUSrc, mem_valid, mem_MemRead, mem_MemWrite, mem_Branch;
  logic wb_valid, wb_RegWrite, wb_MemtoReg, halted, illegal;
  logic [1:0] ex_ALUop; logic [2:0] ex_Funct3; logic [6:0] ex_Funct7;
  logic [4:0] ex_rd, wb_rd; logic [31:0] instret;
  logic b_if_ready, b_ex_valid, b_ex_ALUSrc, b_mem_valid, b_mem_MemRead, b_mem_MemWrite, b_mem_Branch;
  logic b_wb_valid, b_wb_RegWrite, b_wb_MemtoReg, b_halted, b_illegal;
  logic [1:0] b_ex_ALUop; logic [2:0] b_ex_Funct3; logic [6:0] b_ex_Funct7;
  logic [4:0] b_ex_rd, b_wb_rd; logic [2:0] b_instret;

  pipe_ctrl_unit dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
    .stall(stall), .flush(flush), .resume(resume), .ex_valid(ex_valid), .ex_ALUSrc(ex_ALUSrc),
    .ex_ALUop(ex_ALUop), .ex_Funct3(ex_Funct3), .ex_Funct7(ex_Funct7), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_Branch(mem_Branch), .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite),
    .wb_MemtoReg(wb_MemtoReg), .wb_rd(wb_rd), .halted(halted), .illegal(illegal),
    .instret(instret));

  // bubble-on-illegal variant with a narrow counter to expose wrap
  pipe_ctrl_unit #(.CNT_W(3), .HALT_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_ready(b_if_ready),
    .stall(stall), .flush(flush), .resume(resume), .ex_valid(b_ex_valid), .ex_ALUSrc(b_ex_ALUSrc),
    .ex_ALUop(b_ex_ALUop), .ex_Funct3(b_ex_Funct3), .ex_Funct7(b_ex_Funct7), .ex_rd(b_ex_rd),
    .mem_valid(b_mem_valid), .mem_MemRead(b_mem_MemRead), .mem_MemWrite(b_mem_MemWrite),
    .mem_Branch(b_mem_Branch), .wb_valid(b_wb_valid), .wb_RegWrite(b_wb_RegWrite),
    .wb_MemtoReg(b_wb_MemtoReg), .wb_rd(b_wb_rd), .halted(b_halted), .illegal(b_illegal),
    .instret(b_instret));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, sb_cmp = 0, sb_bad = 0;
  logic [17:0] exq[$];
  logic [17:0] sb_exp;
  wire  [17:0] ex_obs = {ex_ALUSrc, ex_ALUop, ex_Funct3, ex_Funct7, ex_rd};

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, rd, op};
  endfunction

  // {ALUSrc, ALUop, Funct3, Funct7, rd} expected in EX
  function automatic logic [17:0] exp_ex(input logic [31:0] i);
    case (i[6:0])
      OP_R:    return {1'b0, 2'b10, i[14:12], i[31:25], i[11:7]};
      OP_LD:   return {1'b1, 2'b00, i[14:12], i[31:25], i[11:7]};
      OP_ST:   return {1'b1, 2'b00, i[14:12], i[31:25], 5'd0};
      OP_BR:   return {1'b0, 2'b01, i[14:12], i[31:25], 5'd0};
      OP_IMM:  return {1'b1, 2'b11, i[14:12], i[31:25], i[11:7]};
      default: return 18'd0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 4))
      0: r[6:0] = OP_R;  1: r[6:0] = OP_LD; 2: r[6:0] = OP_ST;
      3: r[6:0] = OP_BR; default: r[6:0] = OP_IMM;
    endcase
    return r;
  endfunction

  // scoreboard: every EX entry pops the next expected bundle
  always @(negedge clk) begin
    if (!reset) begin
      if (ex_valid) begin
        sb_cmp++;
        if (exq.size() == 0) begin
          sb_bad++; $display("FAIL ex_sb_extra: got %h, required no EX entry", ex_obs);
        end else begin
          sb_exp = exq.pop_front();
          if (ex_obs !== sb_exp) begin
            sb_bad++; $display("FAIL ex_sb: got %h, required %h", ex_obs, sb_exp);
          end
        end
      end else begin
        sb_cmp++;
        if (ex_obs !== 18'd0) begin
          sb_bad++; $display("FAIL ex_bubble_zero: got %h, required 0", ex_obs);
        end
      end
      sb_cmp++;
      if (!mem_valid && {mem_MemRead, mem_MemWrite, mem_Branch} !== 3'b000) begin
        sb_bad++; $display("FAIL mem_bubble_zero: got %b, required 000", {mem_MemRead, mem_MemWrite, mem_Branch});
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic do_reset();
    reset = 1; if_valid = 0; stall = 0; flush = 0; resume = 0; if_instr = '0;
    tick(); tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; if_valid = 1; if_instr = mk(7'h00, 3'd0, 5'd5, OP_R);
    stall = 0; flush = 0; resume = 0;
    tick();
    n_cmp++; if (if_ready !== 1'b0) begin n_bad++; $display("FAIL reset_if_ready: got %b required 0", if_ready); end
    tick();
    n_cmp++; if ({ex_valid, mem_valid, wb_valid, halted, illegal} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b required 00000", {ex_valid, mem_valid, wb_valid, halted, illegal}); end
    n_cmp++; if (instret !== 32'd0) begin n_bad++; $display("FAIL reset_instret: got %0d required 0", instret); end
    reset = 0; if_valid = 0; #1;
    n_cmp++; if (if_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b required 1", if_ready); end
  endtask

  task automatic test_basic();
    logic [31:0] ins [4];
    logic [1:0]  aop [4];
    ins[0] = mk(7'h00, 3'b000, 5'd5, OP_R);  ins[1] = mk(7'h05, 3'b010, 5'd6, OP_LD);
    ins[2] = mk(7'h01, 3'b010, 5'd9, OP_ST); ins[3] = mk(7'h00, 3'b001, 5'd3, OP_BR);
    aop[0] = 2'b10; aop[1] = 2'b00; aop[2] = 2'b00; aop[3] = 2'b01;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if_valid = 1; if_instr = ins[c]; exq.push_back(exp_ex(ins[c]));
      tick();
      n_cmp++; if (ex_ALUop !== aop[c]) begin n_bad++; $display("FAIL basic_aluop_c%0d: got %b required %b", c + 1, ex_ALUop, aop[c]); end
      if (c == 2) begin
        n_cmp++; if (mem_MemRead !== 1'b1) begin n_bad++; $display("FAIL basic_memread_c3: got %b required 1", mem_MemRead); end
        n_cmp++; if ({wb_RegWrite, wb_rd} !== {1'b1, 5'd5}) begin n_bad++; $display("FAIL basic_wb_c3: got %b/%0d required 1/5", wb_RegWrite, wb_rd); end
      end
    end
    if_valid = 0;
    n_cmp++; if ({wb_MemtoReg, mem_MemWrite} !== 2'b11) begin n_bad++; $display("FAIL basic_c4: got %b required 11", {wb_MemtoReg, mem_MemWrite}); end
    tick();
    n_cmp++; if ({mem_Branch, wb_RegWrite, wb_rd} !== {1'b1, 1'b0, 5'd0}) begin
      n_bad++; $display("FAIL basic_c5: got %b/%b/%0d required 1/0/0", mem_Branch, wb_RegWrite, wb_rd); end
    tick();
    n_cmp++; if (instret !== 32'd3) begin n_bad++; $display("FAIL basic_instret_c6: got %0d required 3", instret); end
    tick();
    n_cmp++; if (instret !== 32'd4) begin n_bad++; $display("FAIL basic_instret_c7: got %0d required 4", instret); end
  endtask

  task automatic test_stall();
    logic [31:0] ld, add;
    ld = mk(7'h00, 3'b010, 5'd7, OP_LD); add = mk(7'h00, 3'b000, 5'd8, OP_R);
    do_reset();
    if_valid = 1; if_instr = ld; exq.push_back(exp_ex(ld));
    tick();
    stall = 1; if_instr = add; #1;
    n_cmp++; if (if_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready: got %b required 0", if_ready); end
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL stall_bubble: got %b required 0", ex_valid); end
    stall = 0; exq.push_back(exp_ex(add)); #1;
    n_cmp++; if (if_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready: got %b required 1", if_ready); end
    tick();
    if_valid = 0;
    n_cmp++; if ({ex_valid, ex_rd} !== {1'b1, 5'd8}) begin n_bad++; $display("FAIL stall_held_enters: got %b/%0d required 1/8", ex_valid, ex_rd); end
    tick(); tick(); tick();
    n_cmp++; if (instret !== 32'd2) begin n_bad++; $display("FAIL stall_instret: got %0d required 2", instret); end
  endtask

  task automatic test_flush();
    logic [31:0] br, add, sub;
    br = mk(7'h00, 3'b000, 5'd0, OP_BR); add = mk(7'h00, 3'b000, 5'd10, OP_R);
    sub = mk(7'h20, 3'b000, 5'd11, OP_R);
    do_reset();
    if_valid = 1; if_instr = br;  exq.push_back(exp_ex(br));  tick();
    if_instr = add; exq.push_back(exp_ex(add)); tick();
    flush = 1; if_instr = sub; #1;
    n_cmp++; if (if_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b required 0", if_ready); end
    tick();
    flush = 0; if_valid = 0;
    n_cmp++; if ({mem_valid, ex_valid} !== 2'b00) begin n_bad++; $display("FAIL flush_kill: got %b required 00", {mem_valid, ex_valid}); end
    tick();
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_wb: got %b required 0", wb_valid); end
    tick(); tick();
    n_cmp++; if (instret !== 32'd1) begin n_bad++; $display("FAIL flush_instret: got %0d required 1", instret); end
    stall = 1; flush = 1; if_valid = 1; if_instr = add; #1;
    n_cmp++; if (if_ready !== 1'b0) begin n_bad++; $display("FAIL stallflush_ready: got %b required 0", if_ready); end
    tick();
    stall = 0; flush = 0; if_valid = 0;
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL stallflush_bubble: got %b required 0", ex_valid); end
  endtask

  task automatic test_halt();
    logic [31:0] ins [5];
    ins[0] = mk(7'h00, 3'd0, 5'd1, OP_R);   ins[1] = mk(7'h12, 3'd4, 5'd2, OP_IMM);
    ins[2] = mk(7'h20, 3'd0, 5'd3, OP_R);   ins[3] = mk(7'h00, 3'd2, 5'd4, OP_LD);
    ins[4] = mk(7'h00, 3'd2, 5'd5, OP_ST);
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if_valid = 1; if_instr = ins[c]; exq.push_back(exp_ex(ins[c])); tick();
    end
    if_instr = HALT_I; exq.push_back(exp_ex(HALT_I)); tick();       // cycle 5 -> 6
    if_instr = ins[0]; #1;
    n_cmp++; if (if_ready !== 1'b0) begin n_bad++; $display("FAIL halt_ready_c6: got %b required 0", if_ready); end
    tick();                                                         // c7: resume ignored in DRAIN
    resume = 1;
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_early_c7: got %b required 0", halted); end
    tick();
    resume = 0;
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_early_c8: got %b required 0", halted); end
    tick();
    if_valid = 0;
    n_cmp++; if ({halted, instret} !== {1'b1, 32'd5}) begin n_bad++; $display("FAIL halt_c9: got %b/%0d required 1/5", halted, instret); end
    tick();
    n_cmp++; if (if_ready !== 1'b0) begin n_bad++; $display("FAIL halt_ready_c10: got %b required 0", if_ready); end
    tick(); tick();
    resume = 1; #1;
    n_cmp++; if (if_ready !== 1'b0) begin n_bad++; $display("FAIL halt_ready_c12: got %b required 0", if_ready); end
    tick();
    resume = 0; #1;
    n_cmp++; if ({if_ready, halted} !== 2'b10) begin n_bad++; $display("FAIL halt_resume_c13: got %b required 10", {if_ready, halted}); end
  endtask

  task automatic test_halt_flush();
    do_reset();
    if_valid = 1; if_instr = HALT_I; exq.push_back(exp_ex(HALT_I)); tick();
    if_valid = 0; flush = 1;
    n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL haltflush_marker: got %b required 1", ex_valid); end
    tick();
    flush = 0; #1;
    n_cmp++; if ({if_ready, mem_valid} !== 2'b10) begin n_bad++; $display("FAIL haltflush_run: got %b required 10", {if_ready, mem_valid}); end
    for (int c = 0; c < 6; c++) begin
      n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL haltflush_halted_%0d: got %b required 0", c, halted); end
      tick();
    end
    n_cmp++; if (instret !== 32'd0) begin n_bad++; $display("FAIL haltflush_instret: got %0d required 0", instret); end
    // reset while draining
    if_valid = 1; if_instr = HALT_I; exq.push_back(exp_ex(HALT_I)); tick();
    if_valid = 0; tick();
    reset = 1; tick();
    reset = 0; #1;
    n_cmp++; if ({if_ready, ex_valid, mem_valid, wb_valid} !== 4'b1000) begin
      n_bad++; $display("FAIL drainreset: got %b required 1000", {if_ready, ex_valid, mem_valid, wb_valid}); end
    tick(); tick(); tick(); tick();
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL drainreset_halted: got %b required 0", halted); end
  endtask

  task automatic test_illegal();
    do_reset();
    if_valid = 1; if_instr = ILL_I; exq.push_back(exp_ex(ILL_I)); tick();
    if_valid = 0; #1;
    n_cmp++; if ({illegal, b_illegal, ex_valid, b_ex_valid, if_ready, b_if_ready} !== 6'b111001) begin
      n_bad++; $display("FAIL illegal_c1: got %b required 111001", {illegal, b_illegal, ex_valid, b_ex_valid, if_ready, b_if_ready}); end
    tick(); tick();
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL illegal_halt_c3: got %b required 0", halted); end
    tick();
    n_cmp++; if ({halted, b_halted, instret, b_instret} !== {1'b1, 1'b0, 32'd0, 3'd0}) begin
      n_bad++; $display("FAIL illegal_c4: got %b/%b/%0d/%0d required 1/0/0/0", halted, b_halted, instret, b_instret); end
    resume = 1; tick();
    resume = 0; tick();
    n_cmp++; if ({illegal, halted, b_illegal} !== 3'b001) begin
      n_bad++; $display("FAIL illegal_resume: got %b required 001", {illegal, halted, b_illegal}); end
    do_reset();
    n_cmp++; if (b_illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_reset: got %b required 0", b_illegal); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] cur;
    logic        st;
    int          cnt;
    cnt = 0;
    do_reset();
    cur = rnd_instr();
    for (int c = 0; c < 40; c++) begin
      st = ($urandom_range(0, 3) == 0);
      stall = st; if_valid = 1; if_instr = cur;
      if (!st) begin exq.push_back(exp_ex(cur)); cnt++; cur = rnd_instr(); end
      tick();
    end
    stall = 0; if_valid = 0;
    tick(); tick(); tick(); tick();
    n_cmp++; if (instret !== 32'(cnt)) begin n_bad++; $display("FAIL b2b_instret: got %0d required %0d", instret, cnt); end
    n_cmp++; if (b_instret !== 3'(cnt)) begin n_bad++; $display("FAIL b2b_wrap: got %0d required %0d", b_instret, 3'(cnt)); end
    n_cmp++; if (exq.size() != 0) begin n_bad++; $display("FAIL b2b_sb_left: got %0d entries required 0", exq.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_halt();
    test_halt_flush();
    test_illegal();
    test_back_to_back();
    n_cmp = n_cmp + sb_cmp;
    n_bad = n_bad + sb_bad;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
